orb_frame_reader: RTL and testbench

Read-side counterpart of the orbital word packer. Once the packer's bank-select flag `SW` toggles, this block reads the just-completed RAM bank word by word. It serializes each 12-bit orbital word MSB-first onto a single-bit output, paced by an external bit-rate strobe. It sits between the dual-port orbital RAM read port and the telemetry line driver.

---
 rtl/orb_frame_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_orb_frame_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/orb_frame_reader.sv
// orb_frame_reader
// Reads the orbital RAM bank that the packer has just finished. The read
// starts when the bank-select flag SW toggles. Each 12-bit word goes out
// MSB-first on sOut, one bit per bitEn strobe.
//
// Optional feature: define ORB_SYNC_MARKER_EN to send SYNC_WORD ahead of
// every frame. Without it, the frame starts directly with word 0.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   SW         bank-select flag from the packer (asynchronous)
//   bitEn      one-cycle strobe per output bit period
//   rdData     RAM read data, valid the cycle after rdEn
//   rdEn       one-cycle RAM read strobe
//   rdAddr     {bank, index[10:0]}
//   sOut       serial data, MSB-first
//   sValid     high while sOut carries frame bits
//   frameStart pulse with the first bit of a frame
//   frameDone  pulse when sValid falls
//   ovr        pulse when a toggle arrives while another is still pending
//
// state | meaning
// IDLE  | waiting for a bank toggle, line quiet
// FILL  | word 0 requested, shift register being loaded
// SHIFT | shifting words out, prefetching the next word into hold
// DRAIN | last bit on the line until the closing bitEn
module orb_frame_reader #(
  parameter int          FRAME_WORDS = 2048,
  parameter logic [11:0] SYNC_WORD   = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SW,
  input  logic        bitEn,
  input  logic [11:0] rdData,
  output logic        rdEn,
  output logic [11:0] rdAddr,
  output logic        sOut,
  output logic        sValid,
  output logic        frameStart,
  output logic        frameDone,
  output logic        ovr
);

  typedef enum logic [1:0] {IDLE, FILL, SHIFT, DRAIN} state_t;

  localparam logic [10:0] LAST_IDX = 11'(FRAME_WORDS - 1);

  state_t      state, state_next;
  logic        sw_meta, sw_sync, old_sw, toggle;
  logic        bank, pend_bank, pending;
  logic [10:0] idx;
  logic [11:0] sh, hold;
  logic        hold_ok, pf, first_bit, rd_en_d;
  logic [3:0]  bit_cnt;

  logic shift_act, word_end, load_hold, drain_fin, start_frame, fill_load, new_bank;

  assign toggle = sw_sync ^ old_sw;

`ifndef ORB_SYNC_MARKER_EN
  // Keeps the marker parameter on the interface even though the
  // marker-less build has no use for it.
  logic unused_sync;
  assign unused_sync = ^SYNC_WORD;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    shift_act   = 1'b0;
    load_hold   = 1'b0;
    drain_fin   = 1'b0;
    start_frame = 1'b0;
    fill_load   = 1'b0;
    word_end    = (bit_cnt == 4'd11);
    // A toggle seen this very cycle is newer than anything already latched.
    new_bank    = toggle ? old_sw : pend_bank;
    case (state)
      IDLE: begin
        if (toggle) begin
          start_frame = 1'b1;
          state_next  = FILL;
        end
      end
      FILL: begin
`ifdef ORB_SYNC_MARKER_EN
        // The marker is already in sh, so it may shift right away.
        shift_act  = bitEn;
        state_next = SHIFT;
`else
        if (rd_en_d) begin
          fill_load  = 1'b1;
          state_next = SHIFT;
        end
`endif
      end
      SHIFT: begin
        shift_act = bitEn;
        if (bitEn && word_end) begin
          if (hold_ok) load_hold  = 1'b1;
          else         state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bitEn) begin
          drain_fin = 1'b1;
          // A toggle in the closing cycle counts as pending too.
          if (pending || toggle) begin
            start_frame = 1'b1;
            state_next  = FILL;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta    <= 1'b0;
      sw_sync    <= 1'b0;
      old_sw     <= 1'b0;
      bank       <= 1'b0;
      pend_bank  <= 1'b0;
      pending    <= 1'b0;
      idx        <= '0;
      sh         <= '0;
      hold       <= '0;
      hold_ok    <= 1'b0;
      pf         <= 1'b0;
      first_bit  <= 1'b0;
      rd_en_d    <= 1'b0;
      bit_cnt    <= '0;
      rdEn       <= 1'b0;
      rdAddr     <= '0;
      sOut       <= 1'b0;
      sValid     <= 1'b0;
      frameStart <= 1'b0;
      frameDone  <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      sw_meta    <= SW;
      sw_sync    <= sw_meta;
      old_sw     <= sw_sync;
      rdEn       <= 1'b0;
      frameStart <= 1'b0;
      frameDone  <= 1'b0;
      pf         <= 1'b0;
      rd_en_d    <= rdEn;
      ovr        <= toggle && pending && (state != IDLE);

      if (start_frame) begin
        pending <= 1'b0;
      end else if (toggle && state != IDLE) begin
        pending   <= 1'b1;
        pend_bank <= old_sw;
      end

      // Read data lands in hold, except the first word of a marker-less
      // frame, which goes straight into the shift register.
      if (rd_en_d) begin
        if (fill_load) begin
          sh <= rdData;
          pf <= 1'b1;
        end else begin
          hold    <= rdData;
          hold_ok <= 1'b1;
        end
      end

      if (shift_act) begin
        sOut       <= sh[11];
        sValid     <= 1'b1;
        frameStart <= first_bit;
        first_bit  <= 1'b0;
        bit_cnt    <= word_end ? 4'd0 : bit_cnt + 4'd1;
        if (load_hold) begin
          sh      <= hold;
          hold_ok <= 1'b0;
          pf      <= 1'b1;
        end else begin
          sh <= {sh[10:0], 1'b0};
        end
      end

      // Fetch the following word one cycle after a word enters sh. The read
      // stops at the last index, which also caps the frame length.
      if (pf && idx != LAST_IDX) begin
        idx    <= idx + 11'd1;
        rdEn   <= 1'b1;
        rdAddr <= {bank, idx + 11'd1};
      end

      if (drain_fin) begin
        sOut      <= 1'b0;
        sValid    <= 1'b0;
        frameDone <= 1'b1;
      end

      if (start_frame) begin
        bank      <= new_bank;
        idx       <= '0;
        rdEn      <= 1'b1;
        rdAddr    <= {new_bank, 11'd0};
        hold_ok   <= 1'b0;
        bit_cnt   <= '0;
        first_bit <= 1'b1;
`ifdef ORB_SYNC_MARKER_EN
        sh        <= SYNC_WORD;
`endif
      end
    end
  end

endmodule

// File: tb/tb_orb_frame_reader.sv
module tb_orb_frame_reader;
  localparam int FW = 4;
`ifdef ORB_SYNC_MARKER_EN
  localparam int MK = 1;
`else
  localparam int MK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        SW = 1'b0;
  logic        bitEn = 1'b0;
  logic [11:0] rdData;
  logic        rdEn, sOut, sValid, frameStart, frameDone, ovr;
  logic [11:0] rdAddr;

  always #5 clk = ~clk;

  orb_frame_reader #(.FRAME_WORDS(FW), .SYNC_WORD(12'hFFF)) dut (
    .clk(clk), .rst(rst), .SW(SW), .bitEn(bitEn), .rdData(rdData),
    .rdEn(rdEn), .rdAddr(rdAddr), .sOut(sOut), .sValid(sValid),
    .frameStart(frameStart), .frameDone(frameDone), .ovr(ovr)
  );

  // Synchronous-read RAM model.
  logic [11:0] mem [0:4095];
  always @(posedge clk) if (rdEn) rdData <= mem[rdAddr];

  int ncmp = 0, nmis = 0;
  int cyc = 0;
  int n_start, n_done, n_ovr, n_rd, bad_start, bad_done;
  logic        got_bits [$];
  logic [11:0] got_addr [$];
  int          done_cyc [$];
  int          rd_cyc   [$];
  logic [11:0] exp_q [$];
  logic [11:0] exp_a [$];
  logic        en_seen = 1'b0;
  logic        sv_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    en_seen <= bitEn;
  end

  always @(negedge clk) begin
    if (en_seen && sValid) got_bits.push_back(sOut);
    if (rdEn) begin
      got_addr.push_back(rdAddr);
      rd_cyc.push_back(cyc);
      n_rd++;
    end
    if (frameStart) begin
      n_start++;
      if (!(en_seen && sValid && !sv_prev)) bad_start++;
    end
    if (frameDone) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (!(sv_prev && !sValid)) bad_done++;
    end
    if (ovr) n_ovr++;
    sv_prev = sValid;
  end

  // bitEn strobes spaced 4..7 clocks apart.
  initial begin
    forever begin
      @(negedge clk); bitEn = 1'b1;
      @(negedge clk); bitEn = 1'b0;
      repeat ($urandom_range(2, 5)) @(negedge clk);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got_bits.delete(); got_addr.delete(); done_cyc.delete(); rd_cyc.delete();
    exp_q.delete(); exp_a.delete();
    n_start = 0; n_done = 0; n_ovr = 0; n_rd = 0;
  endtask

  // Expected frame: optional marker, then the bank's words in address order.
  function automatic void add_frame(input logic b);
    if (MK == 1) exp_q.push_back(12'hFFF);
    for (int i = 0; i < FW; i++) begin
      exp_q.push_back(mem[{b, 11'(i)}]);
      exp_a.push_back({b, 11'(i)});
    end
  endfunction

  task automatic check_stream(input string tag);
    logic [11:0] g;
    check({tag, "_nbits"}, got_bits.size(), exp_q.size() * 12);
    for (int w = 0; w < exp_q.size(); w++) begin
      g = '0;
      for (int b = 0; b < 12; b++)
        g = {g[10:0], (w * 12 + b < got_bits.size()) ? got_bits[w * 12 + b] : 1'bx};
      check($sformatf("%s_word%0d", tag, w), g, exp_q[w]);
    end
    check({tag, "_nrd"}, got_addr.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_addr.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_a[i]);
  endtask

  task automatic wait_done(input int n, input int budget);
    int c = 0;
    while (n_done < n && c < budget) begin
      @(negedge clk); c++;
    end
    check("frame_done_in_time", 32'(n_done >= n), 1);
  endtask

  task automatic wait_bits(input int n, input int budget);
    int c = 0;
    while (got_bits.size() < n && c < budget) begin
      @(negedge clk); c++;
    end
    check("bits_reached_in_time", 32'(got_bits.size() >= n), 1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rdEn"}, rdEn, 0);
    check({tag, "_rdAddr"}, rdAddr, 0);
    check({tag, "_sOut"}, sOut, 0);
    check({tag, "_sValid"}, sValid, 0);
    check({tag, "_frameStart"}, frameStart, 0);
    check({tag, "_frameDone"}, frameDone, 0);
    check({tag, "_ovr"}, ovr, 0);
  endtask

  initial begin
    int lat;
    n_start = 0; n_done = 0; n_ovr = 0; n_rd = 0; bad_start = 0; bad_done = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom_range(0, 12'h7FF));

    // Reset and idle with no toggle.
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    clear_obs();
    repeat (60) @(negedge clk);
    check("idle_no_read", n_rd, 0);
    check("idle_sValid", sValid, 0);

    // Test-plan frame from bank 0, SW 0->1.
    mem[0] = 12'h123; mem[1] = 12'h456; mem[2] = 12'h789; mem[3] = 12'h0AB;
    for (int i = 0; i < 4; i++) mem[2048 + i] = 12'h0F0;
    clear_obs();
    add_frame(1'b0);
    SW = 1'b1;
    lat = 0;
    while (!rdEn && lat < 8) begin @(negedge clk); lat++; end
    check("toggle_to_read_latency_le4", 32'(lat <= 4), 1);
    wait_done(1, 2000);
    check_stream("bank0");
    check("bank0_starts", n_start, 1);
    check("bank0_dones", n_done, 1);
    check("bank0_ovr", n_ovr, 0);

    // SW 1->0 reads bank 1.
    repeat (20) @(negedge clk);
    clear_obs();
    add_frame(1'b1);
    SW = 1'b0;
    wait_done(1, 2000);
    check_stream("bank1");
    check("bank1_starts", n_start, 1);

    // Pending toggle during word 2: two back-to-back frames, no overrun.
    for (int i = 0; i < 4; i++) begin
      mem[i] = 12'($urandom_range(0, 12'h7FF));
      mem[2048 + i] = 12'($urandom_range(0, 12'h7FF));
    end
    repeat (20) @(negedge clk);
    clear_obs();
    add_frame(1'b0);
    add_frame(1'b1);
    SW = 1'b1;
    wait_bits((MK + 2) * 12 + 3, 2000);
    SW = 1'b0;
    wait_done(2, 4000);
    check_stream("pend");
    check("pend_starts", n_start, 2);
    check("pend_ovr", n_ovr, 0);
    check("pend_restart_gap_le2",
          32'(rd_cyc.size() > FW && done_cyc.size() > 0 &&
              rd_cyc[FW] >= done_cyc[0] && rd_cyc[FW] - done_cyc[0] <= 2), 1);

    // Two extra toggles in one frame: one ovr, one extra frame, newest bank.
    for (int i = 0; i < 4; i++) begin
      mem[i] = 12'($urandom_range(0, 12'h7FF));
      mem[2048 + i] = mem[i] ^ 12'h001;
    end
    repeat (20) @(negedge clk);
    clear_obs();
    add_frame(1'b0);
    add_frame(1'b0);
    SW = 1'b1;
    wait_bits(15, 2000);
    SW = 1'b0;
    repeat (10) @(negedge clk);
    SW = 1'b1;
    wait_done(2, 4000);
    repeat (300) @(negedge clk);
    check_stream("ovr");
    check("ovr_pulses", n_ovr, 1);
    check("ovr_starts", n_start, 2);
    check("ovr_dones", n_done, 2);

    // Reset mid-frame with a toggle pending; nothing may follow.
    clear_obs();
    SW = 1'b0;
    wait_bits(20, 2000);
    SW = 1'b1;
    repeat (6) @(negedge clk);
    SW = 1'b0;
    rst = 1'b0;
    #1;
    check_quiet("midreset");
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
    repeat (200) @(negedge clk);
    check("post_reset_no_read", n_rd, 0);
    check("post_reset_no_start", n_start, 0);

    check("frameStart_alignment", bad_start, 0);
    check("frameDone_alignment", bad_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
